// File: rtl/app_mult_pkg.sv
// Shared definitions for the approximate-multiplier control path: state codes,
// default widths and the guard-counter width helper.
package app_mult_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_NORM_A = 3'd2,
    ST_NORM_B = 3'd3,
    ST_MULT   = 3'd4,
    ST_DENORM = 3'd5,
    ST_DONE   = 3'd6,
    ST_ZERO   = 3'd7
  } state_e;

  // The guard must count up to 2*width (denormalise fail-safe limit).
  function automatic int guard_width(input int width);
    return $clog2(2 * width + 1);
  endfunction

  localparam int GCNT_W_DEF = guard_width(WIDTH_DEF);

endpackage

// File: rtl/app_mult_guard_cnt.sv
// Guard counter bounding the normalise and denormalise loops, with the two
// terminal compares the sequencer needs.
module app_mult_guard_cnt
  import app_mult_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int GCNT_W = GCNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic at_norm_max,
  output logic at_denorm_max
);

  localparam logic [GCNT_W-1:0] NORM_MAX   = GCNT_W'(WIDTH - 1);
  localparam logic [GCNT_W-1:0] DENORM_MAX = GCNT_W'(2 * WIDTH);

  logic [GCNT_W-1:0] cnt_q;
  logic [GCNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + GCNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_norm_max   = (cnt_q == NORM_MAX);
  assign at_denorm_max = (cnt_q == DENORM_MAX);

endmodule

// File: rtl/app_mult_sequencer.sv
// Control FSM for the approximate multiplier: load, normalise A and B, load the
// reduced product, denormalise, then pulse Done. Outputs decode from state + status.
module app_mult_sequencer
  import app_mult_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int GCNT_W = GCNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic DoneA,
  input  logic DoneB,
  input  logic down_done,
  output logic busy,
  output logic Done,
  output logic rst5,
  output logic loadA,
  output logic loadB,
  output logic ShlA,
  output logic ShlB,
  output logic cntU,
  output logic cntD,
  output logic loadOut,
  output logic ShrOut,
  output logic clrOut
);

  state_e state_q;
  state_e state_d;
  logic   guard_clr;
  logic   guard_en;
  logic   at_norm_max;
  logic   at_denorm_max;

  app_mult_guard_cnt #(
    .WIDTH (WIDTH),
    .GCNT_W(GCNT_W)
  ) u_guard (
    .clk          (clk),
    .rst          (rst),
    .clr          (guard_clr),
    .en           (guard_en),
    .at_norm_max  (at_norm_max),
    .at_denorm_max(at_denorm_max)
  );

  always_comb begin
    state_d   = state_q;
    guard_clr = 1'b0;
    guard_en  = 1'b0;
    busy      = 1'b1;
    Done      = 1'b0;
    rst5      = 1'b0;
    loadA     = 1'b0;
    loadB     = 1'b0;
    ShlA      = 1'b0;
    ShlB      = 1'b0;
    cntU      = 1'b0;
    cntD      = 1'b0;
    loadOut   = 1'b0;
    ShrOut    = 1'b0;
    clrOut    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        loadA     = 1'b1;
        loadB     = 1'b1;
        rst5      = 1'b1;
        guard_clr = 1'b1;
        state_d   = ST_NORM_A;
      end
      // MSB check has priority so an operand needing WIDTH-1 shifts still exits normally.
      ST_NORM_A: begin
        if (DoneA) begin
          state_d   = ST_NORM_B;
          guard_clr = 1'b1;
        end else if (at_norm_max) begin
          state_d = ST_ZERO;
        end else begin
          ShlA     = 1'b1;
          cntU     = 1'b1;
          guard_en = 1'b1;
        end
      end
      ST_NORM_B: begin
        if (DoneB) begin
          state_d   = ST_MULT;
          guard_clr = 1'b1;
        end else if (at_norm_max) begin
          state_d = ST_ZERO;
        end else begin
          ShlB     = 1'b1;
          cntU     = 1'b1;
          guard_en = 1'b1;
        end
      end
      ST_MULT: begin
        loadOut = 1'b1;
        state_d = ST_DENORM;
      end
      // Guard limit stops the loop if down_done never arrives.
      ST_DENORM: begin
        if (down_done || at_denorm_max) begin
          state_d = ST_DONE;
        end else begin
          ShrOut   = 1'b1;
          cntD     = 1'b1;
          guard_en = 1'b1;
        end
      end
      ST_ZERO: begin
        clrOut  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        Done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_app_mult_sequencer.sv
// Directed bench for app_mult_sequencer with a behavioural datapath model
// (A/B operand registers and the shared shift counter) closing the loop.
module tb_app_mult_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic DoneA, DoneB, down_done;
  logic busy, Done, rst5, loadA, loadB, ShlA, ShlB, cntU, cntD, loadOut, ShrOut, clrOut;

  logic [15:0] op_a, op_b;
  logic        dd_stuck;
  logic [15:0] a_q, b_q;
  logic [7:0]  sc_q;

  int n_cmp = 0;
  int n_err = 0;

  app_mult_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .DoneA    (DoneA),
    .DoneB    (DoneB),
    .down_done(down_done),
    .busy     (busy),
    .Done     (Done),
    .rst5     (rst5),
    .loadA    (loadA),
    .loadB    (loadB),
    .ShlA     (ShlA),
    .ShlB     (ShlB),
    .cntU     (cntU),
    .cntD     (cntD),
    .loadOut  (loadOut),
    .ShrOut   (ShrOut),
    .clrOut   (clrOut)
  );

  always #5 clk = ~clk;

  // Behavioural datapath: registered status derived from the operand regs and shift counter.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      sc_q <= '0;
    end else begin
      if (loadA) a_q <= op_a;
      else if (ShlA) a_q <= a_q << 1;
      if (loadB) b_q <= op_b;
      else if (ShlB) b_q <= b_q << 1;
      if (rst5) sc_q <= '0;
      else if (cntU) sc_q <= sc_q + 8'd1;
      else if (cntD) sc_q <= sc_q - 8'd1;
    end
  end

  assign DoneA     = a_q[15];
  assign DoneB     = b_q[15];
  assign down_done = !dd_stuck && (sc_q == 8'd0);

  function automatic logic [11:0] outs();
    return {busy, Done, rst5, loadA, loadB, ShlA, ShlB, cntU, cntD, loadOut, ShrOut, clrOut};
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Called at the negedge right after the start-sample edge; walks until Done.
  task automatic wait_done(output int lat, output int na, output int nb, output int nd,
                           output int nlo, output int nclr, output int viol);
    int k = 0;
    bit seen = 0;
    na = 0; nb = 0; nd = 0; nlo = 0; nclr = 0; viol = 0;
    while (!seen && k < 200) begin
      na   += int'(ShlA);
      nb   += int'(ShlB);
      nd   += int'(ShrOut);
      nlo  += int'(loadOut);
      nclr += int'(clrOut);
      if ((int'(ShlA) + int'(ShlB) + int'(ShrOut)) > 1 || (cntU && cntD)) viol++;
      if (Done) seen = 1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    lat = seen ? k + 1 : -1;
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input bit stuck,
                       input int e_sa, input int e_sb, input int e_sd, input int e_lo,
                       input int e_clr, input int e_lat, input string tag);
    int lat, na, nb, nd, nlo, nclr, viol;
    op_a = a;
    op_b = b;
    dd_stuck = stuck;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, na, nb, nd, nlo, nclr, viol);
    check({tag, ".latency"}, lat, e_lat);
    check({tag, ".ShlA"}, na, e_sa);
    check({tag, ".ShlB"}, nb, e_sb);
    check({tag, ".ShrOut"}, nd, e_sd);
    check({tag, ".loadOut"}, nlo, e_lo);
    check({tag, ".clrOut"}, nclr, e_clr);
    check({tag, ".exclusive"}, viol, 0);
    @(negedge clk);
    check({tag, ".idle_after"}, int'(outs()), 0);
    $display("op %s A=%04h B=%04h lat=%0d ShlA=%0d ShlB=%0d ShrOut=%0d", tag, a, b, lat, na, nb, nd);
  endtask

  initial begin
    int lat, na, nb, nd, nlo, nclr, viol, k;
    rst = 1'b1;
    start = 1'b0;
    op_a = '0;
    op_b = '0;
    dd_stuck = 1'b0;

    #2;
    check("reset.outs", int'(outs()), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_no_start.outs", int'(outs()), 0);

    // Normal op: sA=6, sB=11, counter 17 -> 17 down-shifts.
    do_op(16'h0300, 16'h0011, 1'b0, 6, 11, 17, 1, 0, 40, "norm");
    // Already normalised, counter 0 -> immediate down_done.
    do_op(16'h8000, 16'h8000, 1'b0, 0, 0, 0, 1, 0, 6, "msb");
    // Maximum legal normalisation for both operands.
    do_op(16'h0001, 16'h0001, 1'b0, 15, 15, 30, 1, 0, 66, "lsb");
    // Zero A: 15 shifts, ZERO, DONE.
    do_op(16'h0000, 16'h1234, 1'b0, 15, 0, 0, 0, 1, 19, "zeroA");
    // Zero B after immediate A exit.
    do_op(16'h8000, 16'h0000, 1'b0, 0, 15, 0, 0, 1, 20, "zeroB");
    // down_done stuck low: fail-safe after 32 shifts.
    do_op(16'h0300, 16'h0011, 1'b1, 6, 11, 32, 1, 0, 55, "stuck");
    dd_stuck = 1'b0;

    // Reset while in NORM_B.
    op_a = 16'h0300;
    op_b = 16'h0011;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!ShlB && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("midrst.reached_normb", int'(ShlB), 1);
    #2 rst = 1'b1;
    #1;
    check("midrst.outs_async", int'(outs()), 0);
    @(negedge clk);
    check("midrst.outs_held", int'(outs()), 0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst.idle", int'(outs()), 0);
    $display("midrst reset asserted in NORM_B, outputs cleared");

    // start held high: back-to-back ops with exactly one IDLE cycle between.
    op_a = 16'h8000;
    op_b = 16'h8000;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("held.load1", int'(loadA), 1);
    wait_done(lat, na, nb, nd, nlo, nclr, viol);
    check("held.lat1", lat, 6);
    @(negedge clk);
    check("held.idle_gap", int'(busy), 0);
    @(negedge clk);
    check("held.load2", int'({busy, loadA}), 3);
    wait_done(lat, na, nb, nd, nlo, nclr, viol);
    check("held.lat2", lat, 6);
    check("held.loadOut2", nlo, 1);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("held.final_idle", int'(outs()), 0);
    $display("held back-to-back ops done, second latency=%0d", lat);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
